d16_xalu: RTL

Parametrised, sequential successor to the d16 combinational ALU. It adds a configurable datapath width, registered result and flags, a start/busy/done handshake, iterative multi-bit shifts and an optional iterative multiplier. It sits between the d16 decode stage and register-file writeback. The core stalls on `busy` and captures `s` and the flags on `done`.

---
 rtl/d16_alu_pkg.sv | 32 +++
 rtl/d16_xalu_mul.sv | 47 ++++
 rtl/d16_xalu.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/d16_alu_pkg.sv
// rtl/d16_alu_pkg.sv - shared opcodes, FSM states and flag indices for d16_xalu
package d16_alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_SHL = 4'h3;
    localparam logic [3:0] ALU_SHR = 4'h4;
    localparam logic [3:0] ALU_OR  = 4'h5;
    localparam logic [3:0] ALU_AND = 4'h6;
    localparam logic [3:0] ALU_EQ  = 4'h7;
    localparam logic [3:0] ALU_XOR = 4'h8;
    localparam logic [3:0] ALU_ASR = 4'h9;
    localparam logic [3:0] ALU_MUL = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_O    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR) || (op == ALU_ASR);
    endfunction

endpackage

// File: rtl/d16_xalu_mul.sv
// rtl/d16_xalu_mul.sv - iterative shift-add unsigned multiplier, one bit of b per cycle
// Ports: sys_clk, sys_rst (sync, active-low), start (load a/b), a, b,
//        done (high during the final step), product (value after the current step).
module d16_xalu_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     partial;

    // acc holds {partial product, remaining multiplier bits}; each step adds the
    // multiplicand into the high half when the current multiplier LSB is set, then
    // shifts the whole thing right, keeping the carry in the vacated MSB.
    always_comb begin
        partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        product = {partial, acc[WIDTH-1:1]};
        done    = (cnt == CW'(1));
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc <= product;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/d16_xalu.sv
// rtl/d16_xalu.sv - sequential ALU with registered result/flags and start/busy/done handshake
// Ports: sys_clk, sys_rst (sync, active-low); start, ctrl_alu, flags_we, a, b sampled
//        when idle; busy, done (one-cycle pulse), s, s_hi, flags n/o/z/c.
// Build option: D16_XALU_MUL_EN compiles in the iterative multiplier and s_hi generation.
module d16_xalu
    import d16_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [3:0]       ctrl_alu,
    input  logic             flags_we,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_hi,
    output logic             n,
    output logic             o,
    output logic             z,
    output logic             c
);

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             op_q;
    logic                   fwe_q;
    logic [WIDTH-1:0]       work;
    logic [SHW-1:0]         cnt;
    logic                   o_sticky;
    logic [NUM_FLAGS-1:0]   flags;
    logic [SHW-1:0]         shamt;

    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         diff;
    logic [WIDTH-1:0]       imm_s;
    logic                   imm_c;
    logic                   imm_o;
    logic                   imm_legal;

    logic [WIDTH-1:0]       step_work;
    logic                   step_out;

    assign shamt = b[SHW-1:0];

`ifdef D16_XALU_MUL_EN
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_product;

    d16_xalu_mul #(.WIDTH(WIDTH)) u_mul (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   ((state == ST_IDLE) && start && (ctrl_alu == ALU_MUL)),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    function automatic logic [NUM_FLAGS-1:0] make_flags(
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi,
        input logic             ov,
        input logic             cy
    );
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLAG_N] = lo[WIDTH-1];
        f[FLAG_Z] = (lo == '0) && (hi == '0);
        f[FLAG_O] = ov;
        f[FLAG_C] = cy;
        return f;
    endfunction

    // Single-cycle results straight from the inputs; shifts only land here with k=0.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        imm_s     = '0;
        imm_c     = 1'b0;
        imm_o     = 1'b0;
        imm_legal = 1'b1;
        case (ctrl_alu)
            ALU_ADD: begin
                imm_s = sum[WIDTH-1:0];
                imm_c = sum[WIDTH];
                imm_o = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                imm_s = diff[WIDTH-1:0];
                imm_c = diff[WIDTH];
                imm_o = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SHL, ALU_SHR, ALU_ASR: imm_s = a;
            ALU_OR:  imm_s = a | b;
            ALU_AND: imm_s = a & b;
            ALU_XOR: imm_s = a ^ b;
            ALU_EQ:  imm_s = {{(WIDTH-1){1'b0}}, (a == b)};
            default: imm_legal = 1'b0;
        endcase
    end

    // One bit of shift per cycle; step_out is the bit that falls off this step.
    always_comb begin
        step_work = work;
        step_out  = 1'b0;
        case (op_q)
            ALU_SHL: begin
                step_work = {work[WIDTH-2:0], 1'b0};
                step_out  = work[WIDTH-1];
            end
            ALU_SHR: begin
                step_work = {1'b0, work[WIDTH-1:1]};
                step_out  = work[0];
            end
            ALU_ASR: begin
                step_work = {work[WIDTH-1], work[WIDTH-1:1]};
                step_out  = work[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_DONE;
                    if (is_shift(ctrl_alu) && (shamt != '0)) next_state = ST_SHIFT;
`ifdef D16_XALU_MUL_EN
                    if (ctrl_alu == ALU_MUL) next_state = ST_MUL;
`endif
                end
            end
            ST_SHIFT: if (cnt == SHW'(1)) next_state = ST_DONE;
`ifdef D16_XALU_MUL_EN
            ST_MUL:   if (mul_done) next_state = ST_DONE;
`else
            ST_MUL:   next_state = ST_IDLE;
`endif
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Results are written on the edge that enters DONE so they are valid while done is high.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            op_q     <= '0;
            fwe_q    <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            o_sticky <= 1'b0;
            s        <= '0;
            s_hi     <= '0;
            flags    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= ctrl_alu;
                        fwe_q    <= flags_we;
                        work     <= a;
                        cnt      <= shamt;
                        o_sticky <= 1'b0;
                        if (next_state == ST_DONE) begin
                            s    <= imm_s;
                            s_hi <= '0;
                            if (imm_legal && flags_we)
                                flags <= make_flags(imm_s, '0, imm_o, imm_c);
                        end
                    end
                end
                ST_SHIFT: begin
                    work     <= step_work;
                    cnt      <= cnt - SHW'(1);
                    o_sticky <= o_sticky | ((op_q == ALU_SHL) && step_out);
                    if (cnt == SHW'(1)) begin
                        s    <= step_work;
                        s_hi <= '0;
                        if (fwe_q)
                            flags <= make_flags(step_work, '0,
                                                (op_q == ALU_SHL) && (o_sticky | step_out),
                                                step_out);
                    end
                end
                ST_MUL: begin
`ifdef D16_XALU_MUL_EN
                    if (mul_done) begin
                        s    <= mul_product[WIDTH-1:0];
                        s_hi <= mul_product[2*WIDTH-1:WIDTH];
                        if (fwe_q)
                            flags <= make_flags(mul_product[WIDTH-1:0],
                                                mul_product[2*WIDTH-1:WIDTH],
                                                mul_product[2*WIDTH-1:WIDTH] != '0,
                                                1'b0);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign n = flags[FLAG_N];
    assign o = flags[FLAG_O];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];

endmodule
